// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register-bank arbiter.
// Holds the FSM encoding and the requester ids used by the top and the arbiter.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic ID_SPI  = 1'b0;
  localparam logic ID_CORE = 1'b1;

  localparam int CNT_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer.
// The pointer only moves when a grant is actually issued (i_en high with a request).
module rr_arb2
  import reg_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  logic r_last;
  logic w_id;

  always_comb begin
    w_id = ID_SPI;
    case (i_req)
      2'b10:   w_id = ID_CORE;
      2'b11:   w_id = ~r_last;
      default: w_id = ID_SPI;
    endcase
  end

  assign o_gnt_vld = i_en & (|i_req);
  assign o_gnt_id  = w_id;

  // Pointer starts on the core so the SPI port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)            r_last <= ID_CORE;
    else if (o_gnt_vld) r_last <= w_id;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester register-bank arbiter: IDLE -> ACCESS -> DONE, one access in flight.
// Upper address half is a read-only status region; writes there complete with an error.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              req0,
  input  logic              wr_rdn0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [REG_W-1:0]  wdata0,
  output logic              done0,
  output logic [REG_W-1:0]  rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              wr_rdn1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [REG_W-1:0]  wdata1,
  output logic              done1,
  output logic [REG_W-1:0]  rdata1,
  output logic              err1,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [REG_W-1:0]  bank_wdata,
  input  logic [REG_W-1:0]  bank_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  acc_count
);

  state_t             r_state, w_state_nxt;
  logic               r_wr;
  logic               r_id;
  logic               r_err;
  logic [ADDR_W-1:0]  r_addr;
  logic [REG_W-1:0]   r_wdata;
  logic [REG_W-1:0]   r_rdata;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_gnt_vld;
  logic               w_gnt_id;
  logic               w_idle;
  logic               w_access;
  logic               w_done;
  logic               w_status;
  logic               w_sel_wr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [REG_W-1:0]   w_sel_wdata;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_ACCESS);
  assign w_done   = (r_state == ST_DONE);
  assign w_status = r_addr[ADDR_W-1];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_en      (ena & w_idle),
    .i_req     ({req1, req0}),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_sel_wr    = (w_gnt_id == ID_CORE) ? wr_rdn1 : wr_rdn0;
  assign w_sel_addr  = (w_gnt_id == ID_CORE) ? addr1   : addr0;
  assign w_sel_wdata = (w_gnt_id == ID_CORE) ? wdata1  : wdata0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_gnt_vld) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
      r_id    <= ID_SPI;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idle && w_gnt_vld) begin
        r_wr    <= w_sel_wr;
        r_id    <= w_gnt_id;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      // Response is resolved during ACCESS so DONE only presents registers.
      if (w_access) begin
        r_rdata <= r_wr ? '0 : bank_rdata;
        r_err   <= r_wr & w_status;
      end
      if (w_done) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bank_we    = w_access & r_wr & ~w_status;
  assign bank_addr  = w_access ? r_addr  : '0;
  assign bank_wdata = w_access ? r_wdata : '0;

  assign done0  = w_done & (r_id == ID_SPI);
  assign done1  = w_done & (r_id == ID_CORE);
  assign rdata0 = done0 ? r_rdata : '0;
  assign rdata1 = done1 ? r_rdata : '0;
  assign err0   = done0 & r_err;
  assign err1   = done1 & r_err;

  assign busy      = ~w_idle;
  assign acc_count = r_cnt;

endmodule
